// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the shared shift-register multiply/divide datapath
//   in : clk, rst_n (async, active low), start_i, op_i (0 mul / 1 div),
//        c_i (multiplier LSB), sub_ok_i (minuend >= divisor), divisor_zero_i
//   out: ld_multiplier_o, ld_dividend_o, ad_o, su_o, sh_o, busy_o, done_o, err_o
module muldiv_ctrl #(
  parameter int MUL_STEPS = 4,
  parameter int DIV_STEPS = 5,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic op_i,
  input  logic c_i,
  input  logic sub_ok_i,
  input  logic divisor_zero_i,
  output logic ld_multiplier_o,
  output logic ld_dividend_o,
  output logic ad_o,
  output logic su_o,
  output logic sh_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);
  typedef enum logic [2:0] {IDLE, LOAD, EVAL, SHIFT, DONE} state_e;
  state_e state_q, state_d;
  logic op_q, op_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, lim;
  logic cond;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign lim     = op_q ? CNT_W'(DIV_STEPS) : CNT_W'(MUL_STEPS);
  assign cond    = op_q ? sub_ok_i : c_i;
  assign err_o   = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    err_d           = err_q;
    cnt_d           = cnt_q;
    ld_multiplier_o = 1'b0;
    ld_dividend_o   = 1'b0;
    ad_o            = 1'b0;
    su_o            = 1'b0;
    sh_o            = 1'b0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        op_d    = op_i;
        cnt_d   = '0;
        err_d   = op_i & divisor_zero_i;
        state_d = (op_i & divisor_zero_i) ? DONE : LOAD;
      end
      LOAD: begin
        busy_o          = 1'b1;
        ld_multiplier_o = !op_q;
        ld_dividend_o   = op_q;
        state_d         = EVAL;
      end
      // a true condition spends one cycle on add/subtract before the shift
      EVAL: begin
        busy_o = 1'b1;
        ad_o   = cond & !op_q;
        su_o   = cond & op_q;
        sh_o   = !cond;
        cnt_d  = cond ? cnt_q : cnt_inc;
        state_d = cond ? SHIFT : (cnt_inc == lim) ? DONE : EVAL;
      end
      SHIFT: begin
        busy_o  = 1'b1;
        sh_o    = 1'b1;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == lim) ? DONE : EVAL;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench with a strobe-sequence model for muldiv_ctrl
module tb_muldiv_ctrl;
  logic clk, rst_n, start, op, dz, c, sub_ok;
  logic ldm, ldd, ad, su, sh, busy, done, err;
  logic [7:0] cur_a;
  logic [3:0] cur_b;
  logic [7:0] quo;
  logic [2:0] sh_cnt;
  logic [7:0] got, exp_v;
  logic [7:0] mq[$];
  bit err_m;
  int nchk = 0, nerr = 0;

  muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .c_i(c),
    .sub_ok_i(sub_ok), .divisor_zero_i(dz),
    .ld_multiplier_o(ldm), .ld_dividend_o(ldd), .ad_o(ad), .su_o(su),
    .sh_o(sh), .busy_o(busy), .done_o(done), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got    = {ldm, ldd, ad, su, sh, busy, done, err};
  assign quo    = (cur_b == 4'd0) ? 8'd0 : cur_a / {4'd0, cur_b};
  assign c      = (sh_cnt < 3'd4) ? cur_b[sh_cnt[1:0]] : 1'b0;
  assign sub_ok = (sh_cnt < 3'd5) ? quo[3'd4 - sh_cnt] : 1'b0;

  // datapath stand-in: tracks how many shifts the register has seen
  always @(posedge clk or negedge rst_n)
    if (!rst_n) sh_cnt <= 3'd0;
    else if (ldm | ldd) sh_cnt <= 3'd0;
    else if (sh) sh_cnt <= sh_cnt + 3'd1;

  // vector bits: ldm ldd ad su sh busy done err
  task automatic build();
    logic [7:0] q;
    if (op && dz) mq.push_back(8'b0000_0010);
    else begin
      mq.push_back(op ? 8'b0100_0100 : 8'b1000_0100);
      if (!op) begin
        for (int k = 0; k < 4; k++) begin
          if (cur_b[k]) mq.push_back(8'b0010_0100);
          mq.push_back(8'b0000_1100);
        end
      end else begin
        q = cur_a / {4'd0, cur_b};
        for (int i = 4; i >= 0; i--) begin
          if (q[i]) mq.push_back(8'b0001_0100);
          mq.push_back(8'b0000_1100);
        end
      end
      mq.push_back(8'b0000_0010);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mq.delete();
      err_m = 1'b0;
    end else if (mq.size() != 0) void'(mq.pop_front());
    else if (start) begin
      err_m = op & dz;
      build();
    end

  always @(negedge clk) begin
    exp_v = (mq.size() != 0) ? mq[0] : 8'd0;
    exp_v[0] = err_m;
    if (!rst_n) exp_v = 8'd0;
    nchk++;
    if (got !== exp_v) begin
      nerr++;
      $display("FAIL strobes t=%0t got=%b exp=%b", $time, got, exp_v);
    end
  end

  task automatic wait_done(input int lat0, input int exp_lat, input logic exp_err, input string nm);
    int lat = lat0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    nchk++;
    if (!done || lat != exp_lat) begin
      nerr++;
      $display("FAIL %s latency got=%0d exp=%0d done=%b", nm, lat, exp_lat, done);
    end
    nchk++;
    if (err !== exp_err) begin
      nerr++;
      $display("FAIL %s err got=%b exp=%b", nm, err, exp_err);
    end
  endtask

  task automatic run(input logic o, input logic [7:0] a, input logic [3:0] b, input logic z,
                     input int exp_lat, input logic exp_err, input string nm);
    @(negedge clk);
    op = o; cur_a = a; cur_b = b; dz = z; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, exp_lat, exp_err, nm);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    nerr++;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; dz = 1'b0; cur_a = 8'd0; cur_b = 4'd0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    nchk++;
    if (got !== 8'd0) begin
      nerr++;
      $display("FAIL reset_state got=%b exp=00000000", got);
    end
    run(1'b0, 8'h0B, 4'b0110, 1'b0, 8, 1'b0, "mul_0110");
    run(1'b0, 8'h0B, 4'b0000, 1'b0, 6, 1'b0, "mul_0000");
    run(1'b0, 8'h0F, 4'b1111, 1'b0, 10, 1'b0, "mul_1111");
    run(1'b1, 8'h64, 4'd7, 1'b0, 10, 1'b0, "div_64_7");
    run(1'b1, 8'h55, 4'd0, 1'b1, 1, 1'b1, "div_by_zero");
    run(1'b1, 8'h00, 4'd3, 1'b0, 7, 1'b0, "div_0_3");
    run(1'b1, 8'hF8, 4'd8, 1'b0, 12, 1'b0, "div_f8_8");
    // start pulse while busy must not disturb the running multiply
    @(negedge clk);
    op = 1'b0; cur_b = 4'b0110; dz = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, 8, 1'b0, "mul_pulse");
    @(negedge clk);
    // start held through DONE is taken only in the following IDLE cycle
    @(negedge clk);
    op = 1'b0; cur_b = 4'b0000; start = 1'b1;
    @(negedge clk);
    wait_done(1, 6, 1'b0, "b2b_first");
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, 6, 1'b0, "b2b_second");
    @(negedge clk);
    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    op = 1'b0; cur_b = 4'b0110; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    nchk++;
    if (ad !== 1'b1) begin
      nerr++;
      $display("FAIL pre_reset_ad got=%b exp=1", ad);
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (got !== 8'd0) begin
      nerr++;
      $display("FAIL async_reset got=%b exp=00000000", got);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(1'b1, 8'h64, 4'd7, 1'b0, 10, 1'b0, "div_after_reset");
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
